// File: rtl/segment_capture_pkg.sv
// ---------------------------------------------------------------------------
// segment_capture_pkg
//   Shared definitions for the digit-segment path. The window geometry lives
//   here so the producer-side segment mask and the consumer-side capture
//   block decode exactly the same six boxes.
//   Contents: window constants, edge threshold, counter width,
//             RGB444 field offsets, capture FSM state encoding.
// ---------------------------------------------------------------------------
package segment_capture_pkg;

   // Vertical window, exclusive bounds: V_LO < vcnt < V_HI
   localparam int V_LO    = 100;
   localparam int V_HI    = 350;
   // Box k spans H_LO+k*PITCH < hcnt < H_LO+k*PITCH+BOX_W
   localparam int H_LO    = 100;
   localparam int BOX_W   = 75;
   localparam int PITCH   = 90;
   localparam int NUM_BOX = 6;

   // Edge threshold on the R+G+B nibble sum (range 0..45)
   localparam int THRESH  = 24;
   // Per-box edge counter width
   localparam int CNT_W   = 16;

   // RGB444 field offsets within a 12-bit pixel {R,G,B}
   localparam int NIB_W   = 4;
   localparam int R_LSB   = 8;
   localparam int G_LSB   = 4;
   localparam int B_LSB   = 0;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

endpackage

// File: rtl/segment_box_hit.sv
// ---------------------------------------------------------------------------
// segment_box_hit
//   Combinational box decoder: reports which of the six digit windows the
//   current (hcnt, vcnt) position falls into. All compares are strict, and
//   the boxes do not overlap, so at most one bit of hit_vec is set.
//   Ports:
//     hcnt    in  [9:0]          horizontal pixel counter
//     vcnt    in  [9:0]          vertical line counter
//     hit_vec out [NUM_BOX-1:0]  one-hot (or zero) box membership
// ---------------------------------------------------------------------------
module segment_box_hit
   import segment_capture_pkg::*;
(
   input  logic [9:0]         hcnt,
   input  logic [9:0]         vcnt,
   output logic [NUM_BOX-1:0] hit_vec
);

   logic in_v;

   assign in_v = (vcnt > 10'(V_LO)) && (vcnt < 10'(V_HI));

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BOX; gi++) begin : g_box
         localparam logic [9:0] BOX_LO = 10'(H_LO + gi * PITCH);
         localparam logic [9:0] BOX_HI = 10'(H_LO + gi * PITCH + BOX_W);
         assign hit_vec[gi] = in_v && (hcnt > BOX_LO) && (hcnt < BOX_HI);
      end
   endgenerate

endmodule

// File: rtl/segment_capture.sv
// ---------------------------------------------------------------------------
// segment_capture
//   Counts edge pixels inside each of the six digit windows over a frame,
//   snapshots the counts at the frame boundary and streams them out one box
//   per beat over a valid/ready handshake.
//   Ports:
//     clk        in   pixel clock
//     rst        in   synchronous reset, active-high
//     pix_valid  in   active-video strobe
//     hcnt/vcnt  in   [9:0] timing counters for the current pixel
//     pixel_in   in   [11:0] RGB444 pixel
//     frame_end  in   one-cycle pulse after the last active pixel
//     out_data   out  [CNT_W-1:0] edge count of box out_idx
//     out_idx    out  [2:0] box index 0..5
//     out_valid  out  out_data/out_idx valid
//     out_ready  in   downstream accept
//     overrun    out  sticky: a frame ended while a drain was in progress
// ---------------------------------------------------------------------------
module segment_capture
   import segment_capture_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             pix_valid,
   input  logic [9:0]       hcnt,
   input  logic [9:0]       vcnt,
   input  logic [11:0]      pixel_in,
   input  logic             frame_end,
   output logic [CNT_W-1:0] out_data,
   output logic [2:0]       out_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overrun
);

   localparam logic [2:0] LAST_IDX = 3'(NUM_BOX - 1);

   // Stage 1 signals
   logic [NUM_BOX-1:0] box_hit;
   logic [5:0]         nib_sum;
   logic               is_edge;
   logic [NUM_BOX-1:0] hit_reg;
   logic               s1_frame_end_reg;

   // Stage 2 accumulators and snapshot bank
   logic [CNT_W-1:0]   acc_reg  [NUM_BOX];
   logic [CNT_W-1:0]   acc_inc  [NUM_BOX];
   logic [CNT_W-1:0]   snap_reg [NUM_BOX];

   // Drain FSM
   state_t             state_reg, state_next;
   logic [2:0]         idx_reg, idx_next;
   logic               overrun_reg, overrun_next;
   logic               snap_load;

   // -----------------------------------------------------------------------
   // Stage 1: box decode and edge detect, registered
   // -----------------------------------------------------------------------
   segment_box_hit u_box_hit (
      .hcnt    (hcnt),
      .vcnt    (vcnt),
      .hit_vec (box_hit)
   );

   assign nib_sum = {2'b00, pixel_in[R_LSB +: NIB_W]}
                  + {2'b00, pixel_in[G_LSB +: NIB_W]}
                  + {2'b00, pixel_in[B_LSB +: NIB_W]};
   assign is_edge = (nib_sum >= 6'(THRESH));

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_reg          <= '0;
         s1_frame_end_reg <= 1'b0;
      end else begin
         hit_reg          <= (pix_valid && is_edge) ? box_hit : '0;
         s1_frame_end_reg <= frame_end;
      end
   end

   // -----------------------------------------------------------------------
   // Stage 2: saturating per-box accumulators. acc_inc is the value the
   // accumulator would take this cycle; the snapshot captures it so a hit
   // landing on the boundary cycle still belongs to the finished frame.
   // -----------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_BOX; gi++) begin : g_acc
         assign acc_inc[gi] = (hit_reg[gi] && (acc_reg[gi] != '1))
                            ? acc_reg[gi] + CNT_W'(1)
                            : acc_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_BOX; k++) begin
            acc_reg[k]  <= '0;
            snap_reg[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_BOX; k++) begin
            // Accumulators restart on every frame boundary, even when the
            // snapshot itself is dropped because a drain is still running.
            acc_reg[k] <= s1_frame_end_reg ? '0 : acc_inc[k];
            if (snap_load) begin
               snap_reg[k] <= acc_inc[k];
            end
         end
      end
   end

   // -----------------------------------------------------------------------
   // Drain FSM
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         idx_reg     <= '0;
         overrun_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         overrun_reg <= overrun_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      overrun_next = overrun_reg;
      snap_load    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (s1_frame_end_reg) begin
               snap_load  = 1'b1;
               state_next = DRAIN;
               idx_next   = '0;
            end
         end
         DRAIN: begin
            // out_valid is constant-high in DRAIN, so out_ready alone
            // qualifies a transfer.
            if (out_ready) begin
               if (idx_reg == LAST_IDX) begin
                  state_next = IDLE;
                  idx_next   = '0;
               end else begin
                  idx_next = idx_reg + 3'd1;
               end
            end
            if (s1_frame_end_reg) begin
               overrun_next = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            idx_next   = '0;
         end
      endcase
   end

   // Outputs come straight from registers; out_ready only affects next state.
   assign out_valid = (state_reg == DRAIN);
   assign out_idx   = idx_reg;
   assign out_data  = out_valid ? snap_reg[idx_reg] : '0;
   assign overrun   = overrun_reg;

endmodule

// File: tb/tb_segment_capture.sv
// ---------------------------------------------------------------------------
// tb_segment_capture
//   Directed bench for segment_capture: single-pixel vector table covering
//   box edges and the edge threshold, banded white/black frames, handshake
//   stalls, overrun and mid-drain reset sequences.
// ---------------------------------------------------------------------------
module tb_segment_capture;
   import segment_capture_pkg::*;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             pix_valid = 1'b0;
   logic [9:0]       hcnt = '0;
   logic [9:0]       vcnt = '0;
   logic [11:0]      pixel_in = '0;
   logic             frame_end = 1'b0;
   logic [CNT_W-1:0] out_data;
   logic [2:0]       out_idx;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             overrun;

   int checks = 0;
   int errors = 0;

   logic [15:0] got [0:5];

   typedef struct packed {
      logic [11:0] pix;
      logic [9:0]  h;
      logic [9:0]  v;
      logic [2:0]  box;   // 7 = no box expected to count
      logic [15:0] cnt;
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs [0:NVEC-1];

   segment_capture dut (
      .clk       (clk),
      .rst       (rst),
      .pix_valid (pix_valid),
      .hcnt      (hcnt),
      .vcnt      (vcnt),
      .pixel_in  (pixel_in),
      .frame_end (frame_end),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic send_pixel(input logic [9:0] h, input logic [9:0] v, input logic [11:0] p);
      @(negedge clk);
      pix_valid = 1'b1;
      hcnt      = h;
      vcnt      = v;
      pixel_in  = p;
   endtask

   task automatic pulse_frame_end();
      @(negedge clk);
      pix_valid = 1'b0;
      frame_end = 1'b1;
      @(negedge clk);
      frame_end = 1'b0;
   endtask

   // Rows 99..102 and 348..351 across hcnt 98..628: per box 74 columns and
   // 4 in-window rows (101,102,348,349).
   task automatic send_band(input logic [11:0] p);
      int rows [8] = '{99, 100, 101, 102, 348, 349, 350, 351};
      for (int r = 0; r < 8; r++)
         for (int h = 98; h <= 628; h++)
            send_pixel(10'(h), 10'(rows[r]), p);
   endtask

   // Places n white pixels inside box b on line 200.
   task automatic send_box(input int b, input int n);
      for (int j = 0; j < n; j++)
         send_pixel(10'(H_LO + b * PITCH + 1 + j), 10'd200, 12'hFFF);
   endtask

   // Accepts n beats expecting indices first..first+n-1; ready either held
   // high or toggled every cycle. out_ready is left as last driven.
   task automatic drain_beats(input int first, input int n, input bit toggle);
      int taken = 0;
      int cyc   = 0;
      bit phase = 1'b0;
      while (taken < n && cyc < 400) begin
         @(negedge clk);
         cyc++;
         phase     = ~phase;
         out_ready = toggle ? phase : 1'b1;
         if (out_ready && out_valid) begin
            $display("beat idx=%0d data=%0d", out_idx, out_data);
            check("beat_idx", 32'(out_idx), 32'(first + taken));
            got[first + taken] = out_data;
            taken++;
         end
      end
      if (taken < n) check("drain_timeout_beats", 32'(taken), 32'(n));
   endtask

   task automatic expect_idle_after_drain(input string name);
      @(negedge clk);
      out_ready = 1'b0;
      check(name, 32'(out_valid), 32'd0);
   endtask

   initial begin
      vecs[0]  = '{12'hF80, 10'd101, 10'd101, 3'd0, 16'd0}; // sum 23, below threshold
      vecs[1]  = '{12'hF90, 10'd101, 10'd101, 3'd0, 16'd1}; // sum 24, at threshold
      vecs[2]  = '{12'hFFF, 10'd100, 10'd101, 3'd7, 16'd0}; // left edge excluded
      vecs[3]  = '{12'hFFF, 10'd175, 10'd101, 3'd7, 16'd0}; // right edge excluded
      vecs[4]  = '{12'hFFF, 10'd174, 10'd349, 3'd0, 16'd1}; // last inside corner
      vecs[5]  = '{12'hFFF, 10'd101, 10'd350, 3'd7, 16'd0}; // bottom excluded
      vecs[6]  = '{12'hFFF, 10'd101, 10'd100, 3'd7, 16'd0}; // top excluded
      vecs[7]  = '{12'hFFF, 10'd190, 10'd200, 3'd7, 16'd0}; // box1 left edge
      vecs[8]  = '{12'hFFF, 10'd191, 10'd200, 3'd1, 16'd1};
      vecs[9]  = '{12'hFFF, 10'd264, 10'd200, 3'd1, 16'd1};
      vecs[10] = '{12'hFFF, 10'd625, 10'd200, 3'd7, 16'd0}; // box5 right edge
      vecs[11] = '{12'hFFF, 10'd624, 10'd300, 3'd5, 16'd1};
      vecs[12] = '{12'h0F9, 10'd400, 10'd200, 3'd3, 16'd1}; // G+B = 24

      // Reset
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_idx",   32'(out_idx),   32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_overrun",   32'(overrun),   32'd0);

      // Single-pixel vector table
      for (int i = 0; i < NVEC; i++) begin
         send_pixel(vecs[i].h, vecs[i].v, vecs[i].pix);
         pulse_frame_end();
         drain_beats(0, 6, 1'b0);
         for (int k = 0; k < 6; k++)
            check($sformatf("vec%0d_box%0d", i, k), 32'(got[k]),
                  (vecs[i].box == 3'(k)) ? 32'(vecs[i].cnt) : 32'd0);
         expect_idle_after_drain($sformatf("vec%0d_valid_low", i));
      end

      // White band, ready held high
      send_band(12'hFFF);
      pulse_frame_end();
      drain_beats(0, 6, 1'b0);
      for (int k = 0; k < 6; k++) check($sformatf("white_box%0d", k), 32'(got[k]), 32'd296);
      expect_idle_after_drain("white_valid_low");

      // Black band
      send_band(12'h000);
      pulse_frame_end();
      drain_beats(0, 6, 1'b0);
      for (int k = 0; k < 6; k++) check($sformatf("black_box%0d", k), 32'(got[k]), 32'd0);
      expect_idle_after_drain("black_valid_low");

      // Stall with ready low, then toggled ready
      send_band(12'hFFF);
      pulse_frame_end();
      begin
         int wait_cyc = 0;
         while (!out_valid && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
         end
         check("stall_valid_seen", 32'(out_valid), 32'd1);
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_idx",   32'(out_idx),   32'd0);
         check("stall_data",  32'(out_data),  32'd296);
      end
      drain_beats(0, 6, 1'b1);
      for (int k = 0; k < 6; k++) check($sformatf("toggle_box%0d", k), 32'(got[k]), 32'd296);
      expect_idle_after_drain("toggle_valid_low");

      // Overrun: frame A has k+1 hits in box k; frame B ends while idx 2 waits
      for (int b = 0; b < 6; b++) send_box(b, b + 1);
      pulse_frame_end();
      drain_beats(0, 2, 1'b0);
      @(negedge clk);
      out_ready = 1'b0;
      check("ovr_hold_idx", 32'(out_idx), 32'd2);
      send_box(0, 5);
      pulse_frame_end();
      repeat (3) @(negedge clk);
      check("ovr_flag",      32'(overrun),  32'd1);
      check("ovr_held_idx",  32'(out_idx),  32'd2);
      check("ovr_held_data", 32'(out_data), 32'd3);
      drain_beats(2, 4, 1'b0);
      for (int k = 2; k < 6; k++) check($sformatf("ovr_box%0d", k), 32'(got[k]), 32'(k + 1));
      expect_idle_after_drain("ovr_valid_low");
      send_box(1, 2);
      pulse_frame_end();
      drain_beats(0, 6, 1'b0);
      for (int k = 0; k < 6; k++)
         check($sformatf("post_ovr_box%0d", k), 32'(got[k]), (k == 1) ? 32'd2 : 32'd0);
      expect_idle_after_drain("post_ovr_valid_low");
      check("ovr_sticky", 32'(overrun), 32'd1);

      // Reset in the middle of a drain
      send_box(3, 4);
      pulse_frame_end();
      drain_beats(0, 3, 1'b0);
      @(negedge clk);
      out_ready = 1'b0;
      check("mid_idx",  32'(out_idx),  32'd3);
      check("mid_data", 32'(out_data), 32'd4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_valid",   32'(out_valid), 32'd0);
      check("mid_rst_idx",     32'(out_idx),   32'd0);
      check("mid_rst_data",    32'(out_data),  32'd0);
      check("mid_rst_overrun", 32'(overrun),   32'd0);
      send_box(5, 1);
      pulse_frame_end();
      drain_beats(0, 6, 1'b0);
      for (int k = 0; k < 6; k++)
         check($sformatf("post_rst_box%0d", k), 32'(got[k]), (k == 5) ? 32'd1 : 32'd0);
      expect_idle_after_drain("post_rst_valid_low");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
